// File: rtl/spi_rx_frame_pkg.sv
// spi_pkg: shared types for the SPI frame receiver.
//   state_t     receiver FSM state encoding
//   spi_mode_t  latched {cpol, cpha} bus mode
//   sample_on_rise()  true when the mode samples on the rising spi_clk edge
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  // Modes 0 and 3 sample on the rising edge, modes 1 and 2 on the falling edge.
  function automatic logic sample_on_rise(input spi_mode_t mode);
    return ~(mode.cpol ^ mode.cpha);
  endfunction

endpackage

// File: rtl/spi_rx_frame_sample_edge.sv
// spi_sample_edge: synchronises the asynchronous SPI inputs into clk and
// detects the mode-selected sampling edge plus spi_en rise/fall.
//   clk, nrst     system clock, async active-low reset
//   spi_clk       async SPI clock
//   spi_en        async chip enable
//   spi_data      async serial data
//   mode          latched {cpol, cpha}; selects rising or falling sample edge
//   sample_pulse  one-cycle pulse per sampling edge
//   sample_bit    spi_data aligned with sample_pulse
//   en_rise       one-cycle pulse on synchronised spi_en rise
//   en_fall       one-cycle pulse on synchronised spi_en fall
module spi_sample_edge
  import spi_pkg::*;
#(
  parameter int SYNC_DEPTH = 2
) (
  input  logic      clk,
  input  logic      nrst,
  input  logic      spi_clk,
  input  logic      spi_en,
  input  logic      spi_data,
  input  spi_mode_t mode,
  output logic      sample_pulse,
  output logic      sample_bit,
  output logic      en_rise,
  output logic      en_fall
);

  logic [SYNC_DEPTH-1:0] clk_sync;
  logic [SYNC_DEPTH-1:0] en_sync;
  // One stage longer than clk_sync so the data lines up with the registered
  // sample_pulse rather than with the raw synchronised clock.
  logic [SYNC_DEPTH:0]   data_sync;
  logic                  clk_d;
  logic                  en_d;
  logic                  clk_s;
  logic                  en_s;

  assign clk_s      = clk_sync[SYNC_DEPTH-1];
  assign en_s       = en_sync[SYNC_DEPTH-1];
  assign sample_bit = data_sync[SYNC_DEPTH];

  // The enable chain resets to ones: if spi_en is already high when nrst
  // releases, no rise is reported, so the first frame needs a fresh spi_en rise.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      clk_sync     <= '0;
      en_sync      <= '1;
      data_sync    <= '0;
      clk_d        <= 1'b0;
      en_d         <= 1'b1;
      sample_pulse <= 1'b0;
      en_rise      <= 1'b0;
      en_fall      <= 1'b0;
    end else begin
      clk_sync     <= {clk_sync[SYNC_DEPTH-2:0], spi_clk};
      en_sync      <= {en_sync[SYNC_DEPTH-2:0], spi_en};
      data_sync    <= {data_sync[SYNC_DEPTH-1:0], spi_data};
      clk_d        <= clk_s;
      en_d         <= en_s;
      sample_pulse <= sample_on_rise(mode) ? (clk_s & ~clk_d) : (~clk_s & clk_d);
      en_rise      <= en_s & ~en_d;
      en_fall      <= ~en_s & en_d;
    end
  end

endmodule

// File: rtl/spi_rx_frame.sv
// spi_rx_frame: parametrised SPI slave receiver delivering DATA_WIDTH x
// DATA_DEPTH bit frames through a registered valid/ready handshake.
// Optional feature macro: SPI_RX_ERRCNT_EN builds the saturating error counter;
// without it err_count is tied to zero.
//   clk, nrst     system clock, async active-low reset
//   spi_clk       async SPI clock
//   spi_en        async chip enable, active high
//   spi_data      async serial data
//   cpol, cpha    bus mode, latched on synchronised spi_en rise
//   frame_valid   frame_data holds an unconsumed frame
//   frame_ready   consumer accepts when frame_valid && frame_ready
//   frame_data    received frame, stable while frame_valid
//   overrun       one-cycle pulse: completed frame dropped, output full
//   aborted       one-cycle pulse: spi_en fell mid-frame
//   err_count     saturating count of overrun/aborted pulses
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for spi_en rise
// RECV  | shifting bits in, one per sampling edge
// DONE  | frame complete, ignoring edges until spi_en falls
module spi_rx_frame
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = 2,
  parameter int DATA_DEPTH = 16,
  parameter int SYNC_DEPTH = 2,
  parameter int MSB_FIRST  = 1
) (
  input  logic                             clk,
  input  logic                             nrst,
  input  logic                             spi_clk,
  input  logic                             spi_en,
  input  logic                             spi_data,
  input  logic                             cpol,
  input  logic                             cpha,
  output logic                             frame_valid,
  input  logic                             frame_ready,
  output logic [DATA_WIDTH*DATA_DEPTH-1:0] frame_data,
  output logic                             overrun,
  output logic                             aborted,
  output logic [7:0]                       err_count
);

  localparam int FRAME_BITS = DATA_WIDTH * DATA_DEPTH;
  localparam int CNT_W      = $clog2(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_BITS - 1);

  state_t                  state_q;
  state_t                  state_d;
  spi_mode_t               mode_q;
  logic [CNT_W-1:0]        bit_cnt_q;
  logic [FRAME_BITS-1:0]   shift_q;
  logic [FRAME_BITS-1:0]   shift_next;

  logic sample_pulse;
  logic sample_bit;
  logic en_rise;
  logic en_fall;

  logic cnt_clr;
  logic shift_en;
  logic frame_done;
  logic abort_evt;
  logic load;

  spi_sample_edge #(
    .SYNC_DEPTH (SYNC_DEPTH)
  ) u_sample_edge (
    .clk          (clk),
    .nrst         (nrst),
    .spi_clk      (spi_clk),
    .spi_en       (spi_en),
    .spi_data     (spi_data),
    .mode         (mode_q),
    .sample_pulse (sample_pulse),
    .sample_bit   (sample_bit),
    .en_rise      (en_rise),
    .en_fall      (en_fall)
  );

  always_comb begin
    shift_next = shift_q;
    if (MSB_FIRST != 0) begin
      shift_next = {shift_q[FRAME_BITS-2:0], sample_bit};
    end else begin
      shift_next = {sample_bit, shift_q[FRAME_BITS-1:1]};
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_clr    = 1'b0;
    shift_en   = 1'b0;
    frame_done = 1'b0;
    abort_evt  = 1'b0;
    case (state_q)
      IDLE: begin
        if (en_rise) begin
          cnt_clr = 1'b1;
          state_d = RECV;
        end
      end
      RECV: begin
        // Bus hold time keeps an enable fall and a sampling edge apart, so
        // the fall takes priority only as a matter of form.
        if (en_fall) begin
          abort_evt = (bit_cnt_q != '0);
          state_d   = IDLE;
        end else if (sample_pulse) begin
          shift_en = 1'b1;
          if (bit_cnt_q == LAST_CNT) begin
            frame_done = 1'b1;
            state_d    = DONE;
          end
        end
      end
      DONE: begin
        if (en_fall) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      mode_q    <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
    end else if (cnt_clr) begin
      mode_q.cpol <= cpol;
      mode_q.cpha <= cpha;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
    end else if (shift_en) begin
      bit_cnt_q <= bit_cnt_q + CNT_W'(1);
      shift_q   <= shift_next;
    end else if (abort_evt) begin
      shift_q <= '0;
    end
  end

  // A completing frame loads when the output slot is empty or being drained
  // in the same cycle; otherwise it is dropped and the held frame survives.
  assign load = frame_done && (!frame_valid || frame_ready);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      frame_valid <= 1'b0;
      frame_data  <= '0;
      overrun     <= 1'b0;
      aborted     <= 1'b0;
    end else begin
      if (load) begin
        frame_valid <= 1'b1;
        frame_data  <= shift_next;
      end else if (frame_ready) begin
        frame_valid <= 1'b0;
      end
      overrun <= frame_done && frame_valid && !frame_ready;
      aborted <= abort_evt;
    end
  end

`ifdef SPI_RX_ERRCNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      err_cnt_q <= 8'd0;
    end else if ((overrun || aborted) && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign err_count = err_cnt_q;
`else
  assign err_count = 8'd0;
`endif

endmodule

// File: doc/spi_rx_frame.md
# spi_rx_frame

Parametrised SPI slave receiver, successor to the fixed single-mode receiver in the display input path. Deserialises frames of DATA_WIDTH × DATA_DEPTH bits arriving on an asynchronous SPI bus, supports all four CPOL/CPHA modes and either bit order, and delivers each completed frame through a registered valid/ready handshake. Frames cut short by spi_en deasserting are discarded and flagged, and frames arriving while the output is still held are dropped and flagged, never silently overwritten.

## Interface
- DATA_WIDTH, 2, bits per data element
- DATA_DEPTH, 16, elements per frame; FRAME_BITS = DATA_WIDTH × DATA_DEPTH
- SYNC_DEPTH, 2, synchroniser flops on spi_clk and spi_en (minimum 2)
- MSB_FIRST, 1, 1: first received bit lands in frame_data[FRAME_BITS-1]; 0: lands in bit 0

Ports:
- clk  in  1  system clock
- nrst  in  1  asynchronous active-low reset
- spi_clk  in  1  async SPI clock
- spi_en  in  1  async chip enable, active high
- spi_data  in  1  async serial data
- cpol  in  1  clock idle level; latched on spi_en rising edge
- cpha  in  1  0: sample on leading edge; 1: sample on trailing edge; latched with cpol
- frame_valid  out  1  frame_data holds an unconsumed frame
- frame_ready  in  1  consumer accepts frame when frame_valid && frame_ready
- frame_data  out  FRAME_BITS  received frame, stable while frame_valid
- overrun  out  1  one-cycle pulse: complete frame dropped because the output was full
- aborted  out  1  one-cycle pulse: spi_en fell mid-frame
- err_count  out  8  saturating error counter (see Configuration)

## Operation
- Sampling edge: rising when cpol XOR cpha = 0, else falling. Mode is latched at the synchronised spi_en rise and is ignored mid-frame.
- spi_data is synchronised with SYNC_DEPTH+1 flops. This is one stage more than spi_clk, so the sampled bit aligns with the registered edge detector.
- FSM states:
  - IDLE: waiting for an spi_en rise, which clears the bit counter and enters RECV.
  - RECV: each sampling edge shifts one bit in and increments the counter. The FRAME_BITS-th edge completes the frame and enters DONE. An spi_en fall with 0 < count < FRAME_BITS pulses aborted, discards the shift register and enters IDLE. An spi_en fall with count = 0 returns to IDLE silently.
  - DONE: further sampling edges are ignored until spi_en falls, which enters IDLE. No abort is flagged in DONE.
- Frame completion:
  - If frame_valid = 0, or frame_valid = 1 and frame_ready = 1 in the same cycle: load frame_data and set frame_valid.
  - If frame_valid = 1 and frame_ready = 0: pulse overrun and keep the old frame.
- frame_valid clears on handshake unless a new frame loads in that same cycle.
- An spi_en rise and an spi_en fall are never both seen in one cycle. This is guaranteed by synchronisation.

## Timing
- Reset values: frame_valid 0, frame_data 0, overrun 0, aborted 0, err_count 0. FSM resets to IDLE, counter to 0, latched mode to 0/0.
- Reset mid-frame discards all progress. The first frame after nrst rises needs a fresh spi_en rise.
- Latency: frame_valid is high SYNC_DEPTH+2 clk cycles after the raw spi_clk edge carrying the last bit.
- overrun and aborted are each high for exactly one cycle.
- Bus constraints: spi_clk high and low phases are each ≥ SYNC_DEPTH+2 clk periods. spi_en setup to the first edge and hold after the last edge are each ≥ SYNC_DEPTH+2 clk periods.
- Counter width is $clog2(FRAME_BITS+1) and the counter never wraps.

## Configuration
- SPI_RX_ERRCNT_EN defined: err_count increments on every overrun or aborted pulse and saturates at 255. It clears only on reset.
- Not defined: err_count is tied to 0 and the counter logic is not built.

## Structure
- Package spi_pkg holds state_t (IDLE, RECV, DONE) and the spi_mode_t packed struct {cpol, cpha}.
- FRAME_BITS is a localparam in the module.
- Sub-module spi_sample_edge contains the spi_clk/spi_en/spi_data synchronisers and the mode-selected edge detector. Its outputs are sample_pulse, sample_bit, en_rise and en_fall.

## Test plan
- Mode 0, DATA_WIDTH=2, DATA_DEPTH=4, MSB_FIRST=1, send 0xA5 with frame_ready=1 -> frame_data=0xA5, frame_valid high for 1 cycle, no flags.
- Mode 3, MSB_FIRST=0, send bits 1,0,0,0,0,0,0,1 -> frame_data=0x81.
- spi_en dropped after 5 of 8 bits -> aborted pulse, frame_valid stays 0. The next full 0x3C frame is received intact.
- frame_ready=0, two frames 0x11 then 0x22 -> frame_data stays 0x11, overrun pulses once. With SPI_RX_ERRCNT_EN defined, err_count=1.
- 10 spi_clk edges in one spi_en window -> one frame from the first 8 bits, no abort. nrst pulsed mid-frame -> all outputs return to reset values.
- With SPI_RX_ERRCNT_EN defined, 300 aborted frames -> err_count=255.
